// File: rtl/clean_pkg.sv
// Shared state codes and phase width for the drum self-clean sequencer.
package clean_pkg;

    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [PHASE_W-1:0] ST_FILL  = 3'd1;
    localparam logic [PHASE_W-1:0] ST_SCRUB = 3'd2;
    localparam logic [PHASE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [PHASE_W-1:0] ST_FAULT = 3'd7;

endpackage

// File: rtl/clean_phase_timer.sv
// Phase cycle counter: clears on phase entry, counts while enabled and flags the terminal count.
module clean_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compares the current count, so the last cycle of a phase is the one where hit_o is high.
    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/auto_clean_sequencer.sv
// Drum self-clean controller: FILL -> SCRUB -> DRAIN plus optional rinse passes,
// with abort, quick/deep scrub and a drain-timeout fault.
module auto_clean_sequencer #(
    parameter int  CNT_W     = 8,
    parameter int  FILL_CYC  = 16,
    parameter int  SCRUB_CYC = 32,
    parameter int  RINSE_CYC = 8,
    parameter int  DRAIN_TO  = 64,
    parameter int  RINSE_MAX = 3,
    localparam int RINSE_W   = $clog2(RINSE_MAX + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               deep_mode_i,
    input  logic [RINSE_W-1:0] rinse_req_i,
    input  logic               drum_empty_i,
    output logic               valve_on_o,
    output logic               motor_on_o,
    output logic               pump_on_o,
    output logic               busy_o,
    output logic [2:0]         phase_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic               fault_o
);

    import clean_pkg::*;

    localparam int CNT_MAX = 2 ** CNT_W - 1;

    generate
        if ((2 * SCRUB_CYC - 1 > CNT_MAX) || (DRAIN_TO - 1 > CNT_MAX) ||
            (FILL_CYC - 1 > CNT_MAX) || (RINSE_CYC - 1 > CNT_MAX)) begin : g_cnt_w_check
            $error("auto_clean_sequencer: CNT_W too narrow for the configured phase lengths");
        end
    endgenerate

    localparam logic [CNT_W-1:0]   FILL_TERM  = CNT_W'(FILL_CYC - 1);
    localparam logic [CNT_W-1:0]   QUICK_TERM = CNT_W'(SCRUB_CYC - 1);
    localparam logic [CNT_W-1:0]   DEEP_TERM  = CNT_W'(2 * SCRUB_CYC - 1);
    localparam logic [CNT_W-1:0]   RINSE_TERM = CNT_W'(RINSE_CYC - 1);
    localparam logic [CNT_W-1:0]   DRAIN_TERM = CNT_W'(DRAIN_TO - 1);
    localparam logic [RINSE_W-1:0] RINSE_LIM  = RINSE_W'(RINSE_MAX);

    logic [PHASE_W-1:0] state_q, state_d;
    logic [RINSE_W-1:0] rinse_left_q, rinse_left_d;
    logic               pass_q, pass_d;
    logic               abort_flag_q, abort_flag_d;
    logic               deep_q, deep_d;
    logic               done_d, aborted_d;
    logic               valve_q, motor_q, pump_q, busy_q, done_q, aborted_q, fault_q;
    logic [RINSE_W-1:0] rinse_clamped;
    logic [CNT_W-1:0]   term;
    logic               timer_en;
    logic               hit;

    assign rinse_clamped = (rinse_req_i > RINSE_LIM) ? RINSE_LIM : rinse_req_i;
    assign timer_en      = (state_q == ST_FILL) || (state_q == ST_SCRUB) || (state_q == ST_DRAIN);

    always_comb begin
        term = FILL_TERM;
        case (state_q)
            ST_SCRUB: term = pass_q ? RINSE_TERM : (deep_q ? DEEP_TERM : QUICK_TERM);
            ST_DRAIN: term = DRAIN_TERM;
            default:  term = FILL_TERM;
        endcase
    end

    clean_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_d != state_q),
        .en_i   (timer_en),
        .term_i (term),
        .hit_o  (hit)
    );

    always_comb begin
        state_d      = state_q;
        rinse_left_d = rinse_left_q;
        pass_d       = pass_q;
        abort_flag_d = abort_flag_q;
        deep_d       = deep_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d      = ST_FILL;
                    deep_d       = deep_mode_i;
                    rinse_left_d = rinse_clamped;
                    pass_d       = 1'b0;
                    abort_flag_d = 1'b0;
                end
            end
            ST_FILL, ST_SCRUB: begin
                if (abort_i) begin
                    state_d      = ST_DRAIN;
                    abort_flag_d = 1'b1;
                    rinse_left_d = '0;
                end else if (hit) begin
                    state_d = (state_q == ST_FILL) ? ST_SCRUB : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An empty drum on the timeout cycle still counts as a clean finish.
                if (drum_empty_i) begin
                    if (abort_flag_q) begin
                        state_d   = ST_IDLE;
                        aborted_d = 1'b1;
                    end else if (rinse_left_q != '0) begin
                        state_d      = ST_FILL;
                        rinse_left_d = rinse_left_q - RINSE_W'(1);
                        pass_d       = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rinse_left_q <= '0;
            pass_q       <= 1'b0;
            abort_flag_q <= 1'b0;
            deep_q       <= 1'b0;
            valve_q      <= 1'b0;
            motor_q      <= 1'b0;
            pump_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rinse_left_q <= rinse_left_d;
            pass_q       <= pass_d;
            abort_flag_q <= abort_flag_d;
            deep_q       <= deep_d;
            valve_q      <= (state_d == ST_FILL);
            motor_q      <= (state_d == ST_SCRUB);
            pump_q       <= (state_d == ST_DRAIN);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign valve_on_o = valve_q;
    assign motor_on_o = motor_q;
    assign pump_on_o  = pump_q;
    assign busy_o     = busy_q;
    assign phase_o    = state_q;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign fault_o    = fault_q;

endmodule
